prince_sbox_layer_seq: RTL and testbench

Iterative S-box layer for the PRINCE datapath. It applies the PRINCE S-box (forward) or its inverse to every nibble of a STATE_WIDTH-bit state, LANES nibbles per clock. Area versus latency is therefore tunable. It sits between the key-add/round-constant stage and the M-layer, with valid/ready handshakes on both sides so the round controller can stall it.

---
 rtl/prince_pkg.sv | 27 ++
 rtl/prince_sbox_lane.sv | 17 +
 rtl/prince_sbox_layer_seq.sv | 131 +++++++++++++
 tb/tb_prince_sbox_layer_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_pkg.sv
// prince_pkg
//   Shared definitions for the PRINCE S-box layer:
//   - nibble_t            : 4-bit nibble type
//   - PRINCE_SBOX         : forward S-box, indexed by input nibble 0..F
//   - PRINCE_SBOX_INV     : inverse S-box, indexed by input nibble 0..F
//   - prince_state_e      : FSM state encoding for the iterative layer
package prince_pkg;

  typedef logic [3:0] nibble_t;

  localparam nibble_t PRINCE_SBOX [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
  };

  localparam nibble_t PRINCE_SBOX_INV [16] = '{
    4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } prince_state_e;

endpackage

// File: rtl/prince_sbox_lane.sv
// prince_sbox_lane
//   Combinational single-nibble PRINCE substitution.
//   Ports:
//     nib_i     in  4  nibble to substitute
//     inverse_i in  1  0 = forward S-box, 1 = inverse S-box
//     nib_o     out 4  substituted nibble
module prince_sbox_lane
  import prince_pkg::*;
(
  input  nibble_t nib_i,
  input  logic    inverse_i,
  output nibble_t nib_o
);

  assign nib_o = inverse_i ? PRINCE_SBOX_INV[nib_i] : PRINCE_SBOX[nib_i];

endmodule

// File: rtl/prince_sbox_layer_seq.sv
// prince_sbox_layer_seq
//   Iterative PRINCE S-box layer. A STATE_WIDTH-bit state is substituted
//   LANES nibbles per clock, lowest nibble group first, so a full state takes
//   N_ITER = STATE_WIDTH/(4*LANES) cycles in RUN.
//   Ports:
//     clk, rst   clock (rising edge) and synchronous active-high reset
//     in_valid   input state offered          in_ready  accept possible (IDLE)
//     inverse    0 = S, 1 = S^-1, taken with data_in
//     data_in    state to substitute
//     out_valid  result available (DONE)      out_ready downstream accepts
//     data_out   substituted state (registered)
//     busy       high in RUN or DONE
module prince_sbox_layer_seq
  import prince_pkg::*;
#(
  parameter int STATE_WIDTH = 64,
  parameter int LANES       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   inverse,
  input  logic [STATE_WIDTH-1:0] data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [STATE_WIDTH-1:0] data_out,
  output logic                   busy
);

  localparam int N_NIB  = STATE_WIDTH / 4;
  localparam int N_ITER = N_NIB / LANES;
  localparam int CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int GRP_W  = 4 * LANES;
  localparam logic [STATE_WIDTH-1:0] GRP_MASK = STATE_WIDTH'({GRP_W{1'b1}});
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(N_ITER - 1);

  if (((STATE_WIDTH % 4) != 0) || ((N_NIB % LANES) != 0)) begin : g_param_err
    $error("prince_sbox_layer_seq: STATE_WIDTH must be a multiple of 4 and LANES must divide STATE_WIDTH/4");
  end

  prince_state_e            state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [STATE_WIDTH-1:0]   data_q, data_d;
  logic                     mode_q, mode_d;
  logic                     in_ready_q, out_valid_q, busy_q;

  int                       shamt;
  logic [STATE_WIDTH-1:0]   grp_full;
  logic [GRP_W-1:0]         grp_in;
  logic [GRP_W-1:0]         grp_out;
  logic [STATE_WIDTH-1:0]   data_sub;

  // Lane mux: bring the current nibble group down to bit 0 via a shift, so
  // the lanes see a fixed slice regardless of the counter value.
  always_comb begin
    shamt    = int'(cnt_q) * GRP_W;
    grp_full = data_q >> shamt;
    grp_in   = grp_full[GRP_W-1:0];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    prince_sbox_lane u_lane (
      .nib_i     (grp_in[4*l +: 4]),
      .inverse_i (mode_q),
      .nib_o     (grp_out[4*l +: 4])
    );
  end

  // Lane demux: clear the current group in place and OR the substituted
  // nibbles back in; all other nibbles pass through untouched.
  assign data_sub = (data_q & ~(GRP_MASK << shamt)) | (STATE_WIDTH'(grp_out) << shamt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          mode_d  = inverse;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        data_d = data_sub;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch
  // free and line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_prince_sbox_layer_seq.sv
module tb_prince_sbox_layer_seq;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, inverse, out_valid, out_ready, busy;
  logic [63:0] data_in, data_out;

  // sweep instances
  logic        a_in_valid, a_in_ready, a_inverse, a_out_valid, a_out_ready, a_busy;
  logic [63:0] a_data_in, a_data_out;
  logic        b_in_valid, b_in_ready, b_inverse, b_out_valid, b_out_ready, b_busy;
  logic [63:0] b_data_in, b_data_out;

  int n_checks;
  int n_fail;

  prince_sbox_layer_seq #(.STATE_WIDTH(64), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inverse(inverse), .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .busy(busy)
  );

  prince_sbox_layer_seq #(.STATE_WIDTH(64), .LANES(16)) dut_l16 (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .inverse(a_inverse), .data_in(a_data_in), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .data_out(a_data_out), .busy(a_busy)
  );

  prince_sbox_layer_seq #(.STATE_WIDTH(64), .LANES(1)) dut_l1 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .inverse(b_inverse), .data_in(b_data_in), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .data_out(b_data_out), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one state, let it be accepted, then wait (bounded) for out_valid.
  // lat counts edges from the accepting edge to the first edge with out_valid.
  task automatic run_one(input logic [63:0] d, input logic inv,
                         output logic [63:0] res, output int lat);
    data_in  = d;
    inverse  = inv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = data_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (data_out !== 64'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_zero_latency();
    logic [63:0] res;
    int lat;
    out_ready = 1'b1;
    data_in   = 64'h0;
    inverse   = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL run_flags: in_ready=%b busy=%b want 0/1", in_ready, busy);
    end
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = data_out;
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL zero_latency: got %0d want 4", lat); end
    n_checks++;
    if (res !== 64'hBBBBBBBBBBBBBBBB) begin n_fail++; $display("FAIL zero_data: got %h want bbbbbbbbbbbbbbbb", res); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready: got %b want 0", in_ready); end
    tick();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_handshake: in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_vectors();
    logic [63:0] res;
    int lat;
    out_ready = 1'b1;
    run_one(64'h0123456789ABCDEF, 1'b0, res, lat);
    n_checks++;
    if (res !== 64'hBF32AC916780E5D4) begin n_fail++; $display("FAIL fwd_vector: got %h want bf32ac916780e5d4", res); end
    tick();
    run_one(64'hBF32AC916780E5D4, 1'b1, res, lat);
    n_checks++;
    if (res !== 64'h0123456789ABCDEF) begin n_fail++; $display("FAIL inv_vector: got %h want 0123456789abcdef", res); end
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL inv_latency: got %0d want 4", lat); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [63:0] res;
    int lat;
    out_ready = 1'b0;
    run_one(64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      inverse  = ~i[0];
      data_in  = {$urandom, $urandom};
      tick();
      n_checks++;
      if (data_out !== 64'h4444444444444444 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: data_out=%h out_valid=%b in_ready=%b want 4444444444444444/1/0",
                 i, data_out, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_accept: busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset_midrun();
    logic [63:0] res;
    int lat;
    out_ready = 1'b1;
    data_in   = 64'h0123456789ABCDEF;
    inverse   = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || data_out !== 64'h0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset: out_valid=%b busy=%b data_out=%h in_ready=%b want 0/0/0/1",
               out_valid, busy, data_out, in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_no_output[%0d]: out_valid=%b want 0", i, out_valid); end
    end
    run_one(64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat);
    n_checks++;
    if (res !== 64'h4444444444444444) begin n_fail++; $display("FAIL after_reset_data: got %h want 4444444444444444", res); end
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    a_out_ready = 1'b1;
    a_data_in   = 64'h0123456789ABCDEF;
    a_inverse   = 1'b0;
    a_in_valid  = 1'b1;
    tick();
    a_in_valid  = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 40) begin tick(); lat++; end
    n_checks++;
    if (lat != 1) begin n_fail++; $display("FAIL l16_latency: got %0d want 1", lat); end
    n_checks++;
    if (a_data_out !== 64'hBF32AC916780E5D4) begin n_fail++; $display("FAIL l16_data: got %h want bf32ac916780e5d4", a_data_out); end

    b_out_ready = 1'b1;
    b_data_in   = 64'h0123456789ABCDEF;
    b_inverse   = 1'b0;
    b_in_valid  = 1'b1;
    tick();
    b_in_valid  = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 40) begin tick(); lat++; end
    n_checks++;
    if (lat != 16) begin n_fail++; $display("FAIL l1_latency: got %0d want 16", lat); end
    n_checks++;
    if (b_data_out !== 64'hBF32AC916780E5D4) begin n_fail++; $display("FAIL l1_data: got %h want bf32ac916780e5d4", b_data_out); end
    tick();
  endtask

  task automatic test_mode_toggle();
    int lat;
    out_ready = 1'b1;
    data_in   = 64'h0123456789ABCDEF;
    inverse   = 1'b0;
    in_valid  = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 40) begin
      inverse  = ~inverse;
      data_in  = {$urandom, $urandom};
      in_valid = 1'b0;
      tick();
      lat++;
    end
    n_checks++;
    if (data_out !== 64'hBF32AC916780E5D4) begin n_fail++; $display("FAIL mode_toggle: got %h want bf32ac916780e5d4", data_out); end
    tick();
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    in_valid    = 1'b0;
    inverse     = 1'b0;
    out_ready   = 1'b1;
    data_in     = 64'h0;
    a_in_valid  = 1'b0;
    a_inverse   = 1'b0;
    a_out_ready = 1'b1;
    a_data_in   = 64'h0;
    b_in_valid  = 1'b0;
    b_inverse   = 1'b0;
    b_out_ready = 1'b1;
    b_data_in   = 64'h0;

    test_reset();
    test_zero_latency();
    test_vectors();
    test_backpressure();
    test_reset_midrun();
    test_sweep();
    test_mode_toggle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
